// File: rtl/i2s_mixer_sched.sv
// i2s_mixer_sched: shares one I2S encoder between N sources. Each source fills
// a one-entry slot via valid/ready. Once per frame the sequencer drains all
// slots, attenuates, sums and saturates them. It then updates l/r at a fixed
// frame phase, so the encoder never sees a half-written word.
module i2s_mixer_sched #(
    parameter int N     = 4,
    parameter int FRAME = 1024
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [N*16-1:0] in_l,
    input  logic [N*16-1:0] in_r,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    input  logic [N*4-1:0]  atten,
    input  logic [N-1:0]    mute,
    output logic [15:0]     l,
    output logic [15:0]     r,
    output logic            frame,
    output logic [N-1:0]    underrun
);

    localparam int FCW = (FRAME > 1) ? $clog2(FRAME) : 1;
    localparam int KW  = (N > 1) ? $clog2(N) : 1;
    localparam int AW  = 16 + $clog2(N);

    localparam logic signed [AW-1:0] MAXV = AW'(32767);
    localparam logic signed [AW-1:0] MINV = AW'(-32768);

    typedef enum logic [2:0] {IDLE, LATCH, ACC, SAT, OUT} state_t;

    state_t               state;
    state_t               phase;
    logic [FCW-1:0]       fc;
    logic [KW-1:0]        k;
    logic [N-1:0]         full;
    logic [15:0]          hl [N];
    logic [15:0]          hr [N];
    logic signed [15:0]   wl [N];
    logic signed [15:0]   wr [N];
    logic signed [AW-1:0] acc_l;
    logic signed [AW-1:0] acc_r;
    logic signed [AW-1:0] add_l;
    logic signed [AW-1:0] add_r;
    logic signed [15:0]   sh_l;
    logic signed [15:0]   sh_r;
    logic                 mute_k;
    logic [15:0]          sat_l;
    logic [15:0]          sat_r;
    logic [15:0]          res_l;
    logic [15:0]          res_r;
    logic                 latch;

    assign in_ready = ~full;
    assign latch    = (phase == LATCH);

    // IDLE at fc == 0 acts as LATCH, so the drain lands in the fc == 0 cycle,
    // including the very first cycle after reset is released.
    always_comb begin
        phase = state;
        if (state == IDLE && fc == '0) begin
            phase = LATCH;
        end
    end

    // Free-running frame counter, 0..FRAME-1.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fc <= '0;
        end else if (fc == FCW'(FRAME - 1)) begin
            fc <= '0;
        end else begin
            fc <= fc + FCW'(1);
        end
    end

    // One-entry slots. A handshake on an empty slot in the LATCH cycle is kept for next frame.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            full <= '0;
            for (int i = 0; i < N; i++) begin
                hl[i] <= '0;
                hr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (in_valid[i] && !full[i]) begin
                    hl[i]   <= in_l[16*i +: 16];
                    hr[i]   <= in_r[16*i +: 16];
                    full[i] <= 1'b1;
                end else if (latch) begin
                    full[i] <= 1'b0;
                end
            end
        end
    end

    // Select source k's term for this ACC cycle, attenuated and muted, sign-extended to the accumulator.
    always_comb begin
        sh_l   = '0;
        sh_r   = '0;
        mute_k = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (k == KW'(i)) begin
                sh_l   = wl[i] >>> atten[4*i +: 4];
                sh_r   = wr[i] >>> atten[4*i +: 4];
                mute_k = mute[i];
            end
        end
        add_l = mute_k ? '0 : AW'(sh_l);
        add_r = mute_k ? '0 : AW'(sh_r);
    end

    // Clip the accumulated sums into the 16-bit signed range.
    always_comb begin
        sat_l = acc_l[15:0];
        sat_r = acc_r[15:0];
        if (acc_l > MAXV) begin
            sat_l = 16'h7FFF;
        end else if (acc_l < MINV) begin
            sat_l = 16'h8000;
        end
        if (acc_r > MAXV) begin
            sat_r = 16'h7FFF;
        end else if (acc_r < MINV) begin
            sat_r = 16'h8000;
        end
    end

    // Per-frame sequencer: LATCH, then N ACC cycles, SAT and OUT; only OUT writes l/r.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            k        <= '0;
            acc_l    <= '0;
            acc_r    <= '0;
            res_l    <= '0;
            res_r    <= '0;
            l        <= '0;
            r        <= '0;
            frame    <= 1'b0;
            underrun <= '0;
            for (int i = 0; i < N; i++) begin
                wl[i] <= '0;
                wr[i] <= '0;
            end
        end else begin
            frame    <= 1'b0;
            underrun <= '0;
            case (phase)
                IDLE: begin
                    state <= IDLE;
                end
                LATCH: begin
                    for (int i = 0; i < N; i++) begin
                        wl[i]       <= full[i] ? hl[i] : 16'h0000;
                        wr[i]       <= full[i] ? hr[i] : 16'h0000;
                        underrun[i] <= ~full[i] & ~mute[i];
                    end
                    k     <= '0;
                    state <= ACC;
                end
                ACC: begin
                    acc_l <= acc_l + add_l;
                    acc_r <= acc_r + add_r;
                    if (k == KW'(N - 1)) begin
                        state <= SAT;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                SAT: begin
                    res_l <= sat_l;
                    res_r <= sat_r;
                    state <= OUT;
                end
                OUT: begin
                    l     <= res_l;
                    r     <= res_r;
                    frame <= 1'b1;
                    acc_l <= '0;
                    acc_r <= '0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/i2s_mixer_sched.md
# i2s_mixer_sched

Frame-synchronous mixer and scheduler that shares the I2S encoder between N audio sources. Each source delivers one stereo sample per frame into its own one-entry slot through a valid/ready handshake. Once per stereo frame a sequencer drains all slots, attenuates and sums them, saturates the result, and updates the `l`/`r` words that feed the I2S encoder. The outputs change only at a fixed frame phase, so the encoder never latches a half-updated word.

## Interface
- `N`, 4: number of sources, 1..8.
- `FRAME`, 1024: clocks per stereo frame; must equal the encoder's full L+R period.
- `clock` in 1: system clock, the same clock as the I2S encoder.
- `reset` in 1: asynchronous, active-low reset.
- `in_l` in N*16: left samples, signed two's complement, source i at [16i+15:16i].
- `in_r` in N*16: right samples, same layout as `in_l`.
- `in_valid` in N: source i offers a sample.
- `in_ready` out N: slot i is empty; a sample is accepted when `in_valid[i] & in_ready[i]`.
- `atten` in N*4: per-source arithmetic right shift, 0..15.
- `mute` in N: source i contributes 0.
- `l` out 16: mixed left word to the I2S encoder.
- `r` out 16: mixed right word to the I2S encoder.
- `frame` out 1: one-cycle pulse that coincides with new `l`/`r` values.
- `underrun` out N: one-cycle pulse when an unmuted slot is empty at latch time.

## Operation
- Frame counter `fc`:
  - counts 0..FRAME-1 and wraps to 0;
  - free-running;
  - reset value 0.
- Slot i:
  - holds `hl_i`, `hr_i` and a `full_i` flag;
  - `in_ready[i] = ~full_i`;
  - an accepted handshake stores the sample and sets `full_i`.
- Sequencer states, one state per cycle:
  - IDLE: leave when `fc == 0`, go to LATCH.
  - LATCH: copy each full slot into working registers `wl_i`/`wr_i` and clear all `full_i`. An empty slot loads 0. For an empty slot with `mute[i] == 0`, pulse `underrun[i]`. Go to ACC with index k = 0.
  - ACC: `accL += (mute[k] ? 0 : wl_k >>> atten[k])`; `accR` likewise. `atten`/`mute` are sampled in source k's ACC cycle. Increment k; after k = N-1, go to SAT.
  - SAT: clip `accL`/`accR` to [-32768, 32767] into 16-bit results. Go to OUT.
  - OUT: register the results into `l`/`r`, set `frame` for the next cycle, clear the accumulators. Go to IDLE.
- Accumulator width is 16 + clog2(N) bits, signed; it never wraps.
- Handshake collisions:
  - A handshake in the LATCH cycle on an empty slot is stored for the next frame. That frame still counts as an underrun.
  - A full slot presents `in_ready = 0` in LATCH; the new value is taken from the following cycle on.
- Muted sources:
  - The slot is still drained every frame.
  - No underrun is reported.
- `l`/`r` hold their value for the rest of the frame; no other state writes them.

## Timing
- Reset values:
  - `l = r = 0`;
  - `frame = 0`, `underrun = 0`;
  - all slots empty, so `in_ready` is all ones;
  - `fc = 0`, state IDLE, accumulators 0.
- Schedule per frame:
  - LATCH at `fc = 0`;
  - ACC at `fc = 1..N`;
  - SAT at `fc = N+1`;
  - OUT at `fc = N+2`.
- New `l`/`r` and the `frame` pulse are visible at `fc = N+3`.
- Latency from a sample accepted before `fc = 0` to its appearance on `l`/`r`: N+3 cycles after that `fc = 0` edge.
- After reset is released, the first LATCH happens at the first clock edge with `fc == 0`.
- Reset asserted mid-sequence:
  - immediate return to the reset values;
  - no partial write to `l`/`r`.
- N+3 must be less than FRAME/2 − 16. This keeps the update clear of the encoder's word-load points.

## Test plan
- Single source: load 0x1234 into slot 0 (others muted, atten 0) before `fc = 0` -> `l = 0x1234` with a `frame` pulse at `fc = 7` (N = 4); `underrun = 0`.
- Sum and saturation: all four slots L = 0x4000, R = 0xC000 -> `l = 0x7FFF`, `r = 0x8000`. With atten = 2 on every source -> `l = 0x4000`, `r = 0xC000`.
- Attenuation sign: slot 1 L = 0x8000, atten = 15, others muted -> `l = 0xFFFF`.
- Underrun: slot 2 unmuted and never loaded -> `underrun[2]` pulses at `fc = 1`, it contributes 0, and the other sources still mix. Muting slot 2 -> no pulse.
- Handshake edges:
  - A second sample to a full slot -> `in_ready = 0` and the first sample is kept.
  - A sample offered to an empty slot at `fc = 0` -> underrun that frame; the sample appears on `l` in the next frame.
- Reset mid-sequence: pull `reset` low at `fc = 3` -> `l = r = 0` and `in_ready` all ones at once. After release, no `frame` pulse until the next `fc = N+3`.
